if_fetch: RTL and testbench
===========================

// Module: if_fetch
// PURPOSE
//  Instruction-fetch stage directly upstream of the IF/ID pipeline register. Owns the PC,
//  drives a req/ack instruction-memory port with variable latency, and applies ID-stage
//  redirects (branch/jump). Produces IF_pc_plus_4 and IF_ins; emits the NOP bubble
//  32'h2000_0000 whenever no valid instruction is presented.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value after reset
//  NOP_INS    32'h2000_0000  bubble instruction (addi $0,$0,0)
// PORTS
//  clk           in   1   single clock, rising edge
//  rst           in   1   reset, asynchronous assert, active-low (0 = reset)
//  en            in   1   pipeline advance from hazard unit; 0 = stall (same net as IF/ID en)
//  redirect      in   1   branch/jump taken in ID this cycle
//  redirect_pc   in   32  target PC for redirect
//  imem_req      out  1   fetch request, held until ack
//  imem_addr     out  32  fetch address (= pc), stable while imem_req=1
//  imem_ack      in   1   rdata valid this cycle; completes request
//  imem_rdata    in   32  instruction word
//  IF_pc_plus_4  out  32  pc+4 of presented instruction
//  IF_ins        out  32  presented instruction or NOP_INS
//  fetch_valid   out  1   1 = IF_ins is a real instruction this cycle
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=S_REQ, hold_ins=NOP_INS; imem_req=0 during reset, 1 in first cycle after.
//  States: S_REQ (request outstanding), S_HOLD (word captured, stage stalled), S_DROP (discard pending ack).
//  S_REQ: imem_req=1. On imem_ack: IF_ins=imem_rdata, fetch_valid=1 (combinational, same cycle).
//    ack & en & !redirect -> pc<=pc+4, stay S_REQ (back-to-back fetch, 1 word/cycle max).
//    ack & !en & !redirect -> hold_ins<=imem_rdata, go S_HOLD, pc unchanged.
//    !ack -> IF_ins=NOP_INS, fetch_valid=0.
//  S_HOLD: imem_req=0; IF_ins=hold_ins, fetch_valid=1; en=1 -> pc<=pc+4, go S_REQ.
//  Redirect (priority over en and ack, any state): pc<=redirect_pc; fetch_valid=0, IF_ins=NOP_INS.
//    S_REQ & !ack -> S_DROP; S_REQ & ack, or S_HOLD -> S_REQ. No branch delay slot.
//  S_DROP: imem_req=0, imem_addr=pc, outputs NOP; on imem_ack discard word, go S_REQ.
//    Redirect in S_DROP: pc<=redirect_pc, stay S_DROP.
//  IF_pc_plus_4 = pc+4 (32-bit wrap, 32'hFFFF_FFFC+4 -> 0); redirect_pc[1:0] ignored (forced 00).
//  Reset mid-request: outstanding ack after reset release belongs to old request; memory
//    must drop requests on reset (imem shares rst). No internal ack tracking across reset.
// CONFIGURATION
//  IF_FETCH_PERF_EN defined: adds outputs perf_fetched[31:0] (+1 per cycle with fetch_valid & en
//    & !redirect) and perf_wait[31:0] (+1 per cycle in S_REQ with !ack or in S_DROP); both
//    wrap at 2^32, reset to 0.
//  Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared package mips_pkg: NOP_INS, RESET_PC constants, fetch state encoding
//    (S_REQ=2'd0, S_HOLD=2'd1, S_DROP=2'd2).
//  One sub-module: if_pc_reg (pc register + next-pc mux: redirect_pc / pc+4 / pc).
// TESTING
//  1 rst=0 then released, imem_ack tied 1 -> imem_addr 0,4,8,...; IF_ins=rdata each cycle.
//  2 ack after 3 wait cycles -> IF_ins=32'h2000_0000, fetch_valid=0 for 3 cycles, then word, pc+=4.
//  3 ack with en=0 for 2 cycles -> S_HOLD, imem_req=0, IF_ins stays word; en=1 -> addr +4.
//  4 redirect to 32'h0000_0100 while req pending -> S_DROP, late ack discarded, next addr 0x100.
//  5 redirect with en=0 in S_HOLD -> held word dropped, NOP output, next fetch at redirect_pc.
//  6 pc=32'hFFFF_FFFC fetch -> IF_pc_plus_4=0, next addr 0; perf counters checked if IF_FETCH_PERF_EN.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_pkg
//  Purpose  : Shared constants and fetch-state encoding for the IF stage.
//  Revision : 1.0  initial release
// ============================================================================
package mips_pkg;

    localparam logic [31:0] c_NOP_INS  = 32'h2000_0000;
    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

    // Instructions are word aligned; the low address bits of a target are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_pc_reg.sv
`default_nettype none
// ============================================================================
//  Module   : if_pc_reg
//  Purpose  : Program counter with next-pc select (redirect / pc+4 / hold).
//  Revision : 1.0  initial release
// ============================================================================
module if_pc_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        advance,
    output logic [31:0] pc,
    output logic [31:0] pc_plus_4
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] w_pc_inc;

    assign w_pc_inc = pc_q + 32'd4;

    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = align_pc(redirect_pc);
        end else if (advance) begin
            pc_d = w_pc_inc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= align_pc(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc        = pc_q;
    assign pc_plus_4 = w_pc_inc;

endmodule
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch
//  Purpose  : Instruction fetch stage: owns the PC, runs a req/ack imem port
//             and applies ID-stage redirects. Optional performance counters
//             are built when IF_FETCH_PERF_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module if_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC,
    parameter logic [31:0] NOP_INS  = c_NOP_INS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_pc_plus_4,
    output logic [31:0] IF_ins,
    output logic        fetch_valid
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_wait
`endif
);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic [31:0]  hold_q;
    logic [31:0]  hold_d;
    logic         w_advance;
    logic [31:0]  w_pc;

    if_pc_reg #(
        .RESET_PC    (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .advance     (w_advance),
        .pc          (w_pc),
        .pc_plus_4   (IF_pc_plus_4)
    );

    // Redirect outranks both ack and en: any word seen in that cycle is discarded.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        w_advance   = 1'b0;
        fetch_valid = 1'b0;
        IF_ins      = NOP_INS;
        case (state_q)
            S_REQ: begin
                if (redirect) begin
                    state_d = imem_ack ? S_REQ : S_DROP;
                end else if (imem_ack) begin
                    fetch_valid = 1'b1;
                    IF_ins      = imem_rdata;
                    if (en) begin
                        w_advance = 1'b1;
                    end else begin
                        hold_d  = imem_rdata;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    state_d = S_REQ;
                end else begin
                    fetch_valid = 1'b1;
                    IF_ins      = hold_q;
                    if (en) begin
                        w_advance = 1'b1;
                        state_d   = S_REQ;
                    end
                end
            end
            S_DROP: begin
                // The stale ack retires the old request; a new one starts next cycle.
                if (imem_ack) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_REQ;
            hold_q  <= NOP_INS;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Gated by rst so no request is visible while the memory is itself in reset.
    assign imem_req  = rst & (state_q == S_REQ);
    assign imem_addr = w_pc;

`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_fetched_d;
    logic [31:0] perf_wait_q;
    logic [31:0] perf_wait_d;
    logic        w_wait;

    assign w_wait = ((state_q == S_REQ) & ~imem_ack) | (state_q == S_DROP);

    always_comb begin
        perf_fetched_d = perf_fetched_q + {31'd0, fetch_valid & en};
        perf_wait_d    = perf_wait_q + {31'd0, w_wait};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched_q <= 32'd0;
            perf_wait_q    <= 32'd0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_wait_q    <= perf_wait_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_wait    = perf_wait_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_fetch
//  Purpose  : Randomised scoreboard bench for if_fetch with a variable-latency
//             memory model and an abstract reference of the fetch rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_if_fetch;

    localparam logic [31:0] NOP = 32'h2000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] IF_pc_plus_4;
    logic [31:0] IF_ins;
    logic        fetch_valid;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_wait;
`endif

    if_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .IF_pc_plus_4 (IF_pc_plus_4),
        .IF_ins       (IF_ins),
        .fetch_valid  (fetch_valid)
`ifdef IF_FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_wait    (perf_wait)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        fv;
        logic [31:0] ins;
        logic [31:0] pc4;
        logic [31:0] pf;
        logic [31:0] pw;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp  = 0;
    int   n_err  = 0;
    bit   active = 1'b0;

    // Reference: architectural pc, a word parked by a stall, and a pending stale ack.
    logic [31:0] m_pc = 32'd0;
    bit          m_held = 1'b0;
    logic [31:0] m_word = 32'd0;
    bit          m_disc = 1'b0;
    logic [31:0] m_pf = 32'd0;
    logic [31:0] m_pw = 32'd0;

    // Memory: one outstanding request, latency 0..max_lat cycles.
    bit          busy = 1'b0;
    int          cnt = 0;
    logic [31:0] mem_addr = 32'd0;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int en_pct, input int red_pct, input int max_lat,
                        input bit force_red, input logic [31:0] force_tgt);
        exp_t        e;
        logic [31:0] tgt;
        bit          req_m;
        if (imem_ack) begin
            imem_ack = 1'b0;
            busy     = 1'b0;
        end else if (busy) begin
            cnt--;
            if (cnt == 0) imem_ack = 1'b1;
        end
        if (!busy && !imem_ack && imem_req) begin
            mem_addr = imem_addr;
            cnt      = int'($urandom_range(max_lat, 0));
            if (cnt == 0) imem_ack = 1'b1;
            else          busy = 1'b1;
        end
        imem_rdata = imem_ack ? memword(mem_addr) : $urandom;
        en         = (int'($urandom_range(99, 0)) < en_pct);
        redirect   = force_red || (int'($urandom_range(99, 0)) < red_pct);
        case ($urandom_range(3, 0))
            0:       tgt = 32'h0000_0100;
            1:       tgt = 32'hFFFF_FFFC;
            2:       tgt = 32'hFFFF_FFF1;
            default: tgt = $urandom;
        endcase
        if (force_red) tgt = force_tgt;
        redirect_pc = redirect ? tgt : $urandom;

        req_m  = !m_held && !m_disc;
        e.req  = req_m;
        e.addr = m_pc;
        e.pc4  = m_pc + 32'd4;
        e.pf   = m_pf;
        e.pw   = m_pw;
        if (redirect) begin
            e.fv = 1'b0; e.ins = NOP;
        end else if (m_held) begin
            e.fv = 1'b1; e.ins = m_word;
        end else if (req_m && imem_ack) begin
            e.fv = 1'b1; e.ins = imem_rdata;
        end else begin
            e.fv = 1'b0; e.ins = NOP;
        end
        sbq.push_back(e);
        active = 1'b1;

        if (e.fv && en) m_pf++;
        if ((req_m && !imem_ack) || m_disc) m_pw++;
        tgt = tgt & 32'hFFFF_FFFC;
        if (m_disc) begin
            if (imem_ack) m_disc = 1'b0;
            if (redirect) m_pc = tgt;
        end else if (m_held) begin
            if (redirect) begin
                m_held = 1'b0; m_pc = tgt;
            end else if (en) begin
                m_held = 1'b0; m_pc = m_pc + 32'd4;
            end
        end else begin
            if (redirect) begin
                m_pc = tgt;
                if (!imem_ack) m_disc = 1'b1;
            end else if (imem_ack) begin
                if (en) m_pc = m_pc + 32'd4;
                else begin
                    m_held = 1'b1; m_word = imem_rdata;
                end
            end
        end
    endtask

    task automatic run(input int n, input int en_pct, input int red_pct, input int max_lat,
                       input bit force_red, input logic [31:0] force_tgt);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            step(en_pct, red_pct, max_lat, force_red && (i == 0), force_tgt);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (active) begin
                if (sbq.size() == 0) begin
                    check("scoreboard_underflow", 32'd0, 32'd1);
                end else begin
                    e = sbq.pop_front();
                    check("imem_req", {31'd0, imem_req}, {31'd0, e.req});
                    check("imem_addr", imem_addr, e.addr);
                    check("fetch_valid", {31'd0, fetch_valid}, {31'd0, e.fv});
                    check("IF_ins", IF_ins, e.ins);
                    check("IF_pc_plus_4", IF_pc_plus_4, e.pc4);
`ifdef IF_FETCH_PERF_EN
                    check("perf_fetched", perf_fetched, e.pf);
                    check("perf_wait", perf_wait, e.pw);
`endif
                end
            end
        end
    end

    initial begin : driver
        repeat (3) @(negedge clk);
        check("reset_imem_req", {31'd0, imem_req}, 32'd0);
        check("reset_IF_ins", IF_ins, NOP);
        check("reset_imem_addr", imem_addr, 32'd0);
        check("reset_pc_plus_4", IF_pc_plus_4, 32'd4);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("release_imem_req", {31'd0, imem_req}, 32'd1);
        check("release_fetch_valid", {31'd0, fetch_valid}, 32'd0);

        run(30, 100, 0, 0, 1'b0, 32'd0);          // zero-latency streaming
        run(10, 100, 0, 0, 1'b1, 32'hFFFF_FFFC);  // wrap at top of memory
        run(40, 100, 0, 3, 1'b0, 32'd0);          // wait states
        run(40, 40, 0, 3, 1'b0, 32'd0);           // stalls into hold
        run(3000, 70, 8, 4, 1'b0, 32'd0);         // full random mix
        @(negedge clk);
        active = 1'b0;
        #2;
        check("scoreboard_drained", sbq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
